// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package imem_pkg;

    localparam logic [31:0] NOP = 32'hE1A00000;  // MOV R0,R0

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } resp_t;

    function automatic logic latency_legal(input int unsigned lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO with flush; DEPTH must be a power of two (>= 2).
module resp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = storage[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) storage[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: fixed-latency fetch pipe feeding an in-order
// response FIFO, with flush cancel and a preload write port.
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned MAX_OUT     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic              rsp_err,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(MAX_OUT) + 1;
    localparam int unsigned PC_W  = $clog2(LATENCY) + 1;

    if (!latency_legal(LATENCY)) begin : g_bad_latency
        $error("imem_fetch_responder: LATENCY must be within 1..4");
    end

    logic [31:0]      mem [DEPTH_WORDS];
    logic             accept;
    logic             misaligned;
    logic             out_of_range;
    logic             ld_in_range;
    resp_t            lookup;
    logic             push;
    resp_t            push_data;
    logic [PC_W-1:0]  pipe_count;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      occupancy;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    resp_t            head;
    logic             unused_ld_lo;
    logic             unused_full;

    assign unused_ld_lo = ^ld_addr[1:0];
    assign unused_full  = fifo_full;

    // Pipe plus queue never exceeds MAX_OUT, so the FIFO cannot overflow.
    assign occupancy = 32'(pipe_count) + 32'(fifo_count);
    assign req_ready = reset && !flush && (occupancy < MAX_OUT);
    assign accept    = req_valid && req_ready;

    assign misaligned   = (req_addr[1:0] != 2'b00);
    assign out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
    assign ld_in_range  = !(|ld_addr[ADDR_W-1:IDX_W+2]);

    always_comb begin
        lookup.err   = misaligned || out_of_range;
        lookup.instr = lookup.err ? NOP : mem[req_addr[IDX_W+1:2]];
    end

    // Nonblocking write means a same-cycle fetch sees the old word.
    always_ff @(posedge clk) begin
        if (ld_en && ld_in_range) mem[ld_addr[IDX_W+1:2]] <= ld_data;
    end

    // The FIFO write is the final latency stage, so the pipe holds LATENCY-1.
    if (LATENCY == 1) begin : g_direct
        assign push       = accept;
        assign push_data  = lookup;
        assign pipe_count = '0;
    end else begin : g_pipe
        localparam int unsigned STAGES = LATENCY - 1;

        logic [STAGES-1:0] pipe_valid;
        resp_t             pipe_data [STAGES];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                pipe_valid <= '0;
            end else if (flush) begin
                pipe_valid <= '0;
            end else begin
                pipe_valid[0] <= accept;
                for (int i = 1; i < STAGES; i++) pipe_valid[i] <= pipe_valid[i-1];
            end
        end

        always_ff @(posedge clk) begin
            pipe_data[0] <= lookup;
            for (int i = 1; i < STAGES; i++) pipe_data[i] <= pipe_data[i-1];
        end

        always_comb begin
            pipe_count = '0;
            for (int i = 0; i < STAGES; i++) begin
                if (pipe_valid[i]) pipe_count = pipe_count + PC_W'(1);
            end
        end

        assign push      = pipe_valid[STAGES-1];
        assign push_data = pipe_data[STAGES-1];
    end

    resp_fifo #(
        .WIDTH ($bits(resp_t)),
        .DEPTH (MAX_OUT)
    ) u_resp_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_instr = rsp_valid ? head.instr : 32'h0;
    assign rsp_err   = rsp_valid ? head.err : 1'b0;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed self-checking bench for imem_fetch_responder (LATENCY=2, MAX_OUT=4).
module tb_imem_fetch_responder;

    localparam logic [31:0] NOP = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        flush = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    int checks = 0;
    int failures = 0;

    logic [31:0] prog [4] = '{32'hE3A01001, 32'hE3A02002, 32'hE0813002, 32'hEAFFFFFE};

    always #5 clk = ~clk;

    imem_fetch_responder #(
        .ADDR_W      (32),
        .DEPTH_WORDS (256),
        .LATENCY     (2),
        .MAX_OUT     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .flush     (flush),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_instr !== 32'h0) begin failures++; $display("FAIL reset_rsp_instr: got %h want 00000000", rsp_instr); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_release_valid: got %b want 0", rsp_valid); end
    endtask

    task automatic preload();
        for (int k = 0; k < 4; k++) begin
            tick();
            ld_en = 1'b1;
            ld_addr = 32'(k * 4);
            ld_data = prog[k];
        end
        tick();
        ld_en = 1'b0;
    endtask

    task automatic test_in_order();
        logic exp_v;
        for (int i = 0; i < 8; i++) begin
            tick();
            rsp_ready = 1'b1;
            req_valid = (i < 4);
            req_addr = 32'(i * 4);
            #1;
            exp_v = (i >= 2) && (i < 6);
            if (i < 4) begin
                checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL inorder_ready c%0d: got %b want 1", i, req_ready); end
            end
            checks++; if (rsp_valid !== exp_v) begin failures++; $display("FAIL inorder_valid c%0d: got %b want %b", i, rsp_valid, exp_v); end
            if (exp_v) begin
                checks++; if (rsp_instr !== prog[i-2]) begin failures++; $display("FAIL inorder_instr c%0d: got %h want %h", i, rsp_instr, prog[i-2]); end
                checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL inorder_err c%0d: got %b want 0", i, rsp_err); end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic        exp_v;
        logic        exp_ready;
        logic [31:0] exp_instr;
        for (int i = 0; i < 11; i++) begin
            tick();
            rsp_ready = (i >= 6);
            req_valid = (i < 6);
            req_addr = 32'((i < 4 ? i : 0) * 4);
            #1;
            exp_ready = (i < 4) || (i >= 7);
            exp_v = (i >= 2) && (i <= 9);
            exp_instr = (i >= 6) ? prog[i-6] : prog[0];
            checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL bp_ready c%0d: got %b want %b", i, req_ready, exp_ready); end
            checks++; if (rsp_valid !== exp_v) begin failures++; $display("FAIL bp_valid c%0d: got %b want %b", i, rsp_valid, exp_v); end
            if (exp_v) begin
                checks++; if (rsp_instr !== exp_instr) begin failures++; $display("FAIL bp_instr c%0d: got %h want %h", i, rsp_instr, exp_instr); end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_errors();
        logic exp_v;
        for (int i = 0; i < 5; i++) begin
            tick();
            rsp_ready = 1'b1;
            req_valid = (i < 2);
            req_addr = (i == 0) ? 32'h2 : 32'h400;
            #1;
            exp_v = (i == 2) || (i == 3);
            checks++; if (rsp_valid !== exp_v) begin failures++; $display("FAIL err_valid c%0d: got %b want %b", i, rsp_valid, exp_v); end
            if (exp_v) begin
                checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL err_flag c%0d: got %b want 1", i, rsp_err); end
                checks++; if (rsp_instr !== NOP) begin failures++; $display("FAIL err_instr c%0d: got %h want %h", i, rsp_instr, NOP); end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] addrs [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h4};
        logic        exp_v;
        logic [31:0] exp_instr;
        for (int i = 0; i < 10; i++) begin
            tick();
            rsp_ready = (i >= 4);
            flush = (i == 3);
            req_valid = (i <= 4);
            req_addr = addrs[i <= 4 ? i : 0];
            #1;
            exp_v = (i == 2) || (i == 3) || (i == 6);
            exp_instr = (i == 6) ? prog[1] : prog[0];
            if (i == 3) begin
                checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL flush_ready_in_flush: got %b want 0", req_ready); end
            end
            if (i == 4) begin
                checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL flush_ready_after: got %b want 1", req_ready); end
            end
            checks++; if (rsp_valid !== exp_v) begin failures++; $display("FAIL flush_valid c%0d: got %b want %b", i, rsp_valid, exp_v); end
            if (exp_v) begin
                checks++; if (rsp_instr !== exp_instr) begin failures++; $display("FAIL flush_instr c%0d: got %h want %h", i, rsp_instr, exp_instr); end
            end
        end
        flush = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic test_same_cycle_write();
        logic [31:0] exp_tab [3] = '{32'hE0813002, 32'h12345678, 32'hE3A01001};
        logic        exp_v;
        for (int i = 0; i < 7; i++) begin
            tick();
            rsp_ready = 1'b1;
            ld_en = (i <= 1);
            ld_addr = (i == 0) ? 32'h8 : 32'h400;
            ld_data = (i == 0) ? 32'h12345678 : 32'hDEADBEEF;
            req_valid = (i <= 2);
            req_addr = (i == 2) ? 32'h0 : 32'h8;
            #1;
            exp_v = (i >= 2) && (i <= 4);
            checks++; if (rsp_valid !== exp_v) begin failures++; $display("FAIL wr_valid c%0d: got %b want %b", i, rsp_valid, exp_v); end
            if (exp_v) begin
                checks++; if (rsp_instr !== exp_tab[i-2]) begin failures++; $display("FAIL wr_instr c%0d: got %h want %h", i, rsp_instr, exp_tab[i-2]); end
                checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL wr_err c%0d: got %b want 0", i, rsp_err); end
            end
        end
        ld_en = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic exp_v;
        tick();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight_valid: got %b want 1", rsp_valid); end
        reset = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_instr !== 32'h0) begin failures++; $display("FAIL mid_reset_instr: got %h want 00000000", rsp_instr); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ready: got %b want 0", req_ready); end
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            req_valid = (i == 0);
            req_addr = 32'hC;
            #1;
            exp_v = (i == 2);
            if (i == 0) begin
                checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL cold_ready: got %b want 1", req_ready); end
            end
            checks++; if (rsp_valid !== exp_v) begin failures++; $display("FAIL cold_valid c%0d: got %b want %b", i, rsp_valid, exp_v); end
            if (exp_v) begin
                checks++; if (rsp_instr !== prog[3]) begin failures++; $display("FAIL cold_instr: got %h want %h", rsp_instr, prog[3]); end
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        preload();
        test_in_order();
        test_backpressure();
        test_errors();
        test_flush();
        test_same_cycle_write();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
